// File: rtl/mag_comp_serial.sv
// Bit-serial unsigned magnitude comparator: scans captured operands MSB first, one bit per clock.
// Define MAG_COMP_SERIAL_EARLY_EXIT_EN to end the scan at the first differing bit.
module mag_comp_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             bothEqual,
    output logic             A_greater,
    output logic             B_greater
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t         state, stateNext;
    logic [WIDTH-1:0] aReg, bReg;
    logic [IW-1:0]  idx;
    logic           decA, decB;
    logic           aBit, bBit, lastBit, scanEnd;
    logic           nextA, nextB;

    // Once either decision flag is set, later bits are ignored.
    always_comb begin
        aBit    = aReg[idx];
        bBit    = bReg[idx];
        lastBit = (idx == '0);
        nextA   = decA | (~decA & ~decB & aBit & ~bBit);
        nextB   = decB | (~decA & ~decB & ~aBit & bBit);
`ifdef MAG_COMP_SERIAL_EARLY_EXIT_EN
        scanEnd = lastBit | (aBit ^ bBit);
`else
        scanEnd = lastBit;
`endif
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = COMPARE;
            COMPARE: if (scanEnd) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign busy = (state == COMPARE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            aReg      <= '0;
            bReg      <= '0;
            idx       <= '0;
            decA      <= 1'b0;
            decB      <= 1'b0;
            bothEqual <= 1'b0;
            A_greater <= 1'b0;
            B_greater <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg      <= a;
                        bReg      <= b;
                        idx       <= IW'(WIDTH - 1);
                        decA      <= 1'b0;
                        decB      <= 1'b0;
                        bothEqual <= 1'b0;
                        A_greater <= 1'b0;
                        B_greater <= 1'b0;
                    end
                end
                COMPARE: begin
                    decA <= nextA;
                    decB <= nextB;
                    // Index stops at zero; the scan always ends there.
                    if (!lastBit) idx <= idx - 1'b1;
                    if (scanEnd) begin
                        A_greater <= nextA;
                        B_greater <= nextB;
                        bothEqual <= ~nextA & ~nextB;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
